accm: RTL and testbench



---
 rtl/accm.sv | 46 ++++
 tb/tb_accm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/accm.sv
// Modulo-M accumulator: adds X into an 11-bit running sum on ce edges,
// with a combinational wrap lookahead (Mx) and a registered one-cycle carry (CO).
module accm #(
  parameter int M = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [7:0]  X,
  output logic [10:0] ACC,
  output logic        CO,
  output logic        Mx
);

  logic [10:0] acc_q, acc_d;
  logic        co_q, co_d;
  logic [11:0] sum;
  logic        wrap;

  always_comb begin
    // 12-bit sum so ACC+X never truncates before the modulus compare
    sum   = {1'b0, acc_q} + {4'b0000, X};
    wrap  = (sum >= 12'(M));
    acc_d = acc_q;
    co_d  = 1'b0;
    if (ce) begin
      acc_d = wrap ? 11'(sum - 12'(M)) : sum[10:0];
      co_d  = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      co_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      co_q  <= co_d;
    end
  end

  assign ACC = acc_q;
  assign CO  = co_q;
  assign Mx  = wrap;

endmodule

// File: tb/tb_accm.sv
// Scoreboard bench for accm: the driver pushes model expectations, a monitor
// compares Mx mid-cycle and ACC/CO just after each rising edge.
module tb_accm;

  localparam int M = 2000;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [7:0]  X;
  logic [10:0] ACC;
  logic        CO;
  logic        Mx;

  accm #(.M(M)) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .X  (X),
    .ACC(ACC),
    .CO (CO),
    .Mx (Mx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int co;
  } exp_t;

  exp_t exp_q[$];
  int   mx_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int co_count = 0;
  int m_acc    = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on the running total
  task automatic step(input logic r, input logic c, input int x);
    int   s;
    exp_t e;
    @(negedge clk);
    rst = r;
    ce  = c;
    X   = 8'(x);
    s   = m_acc + x;
    mx_q.push_back((s >= M) ? 1 : 0);
    if (r) begin
      m_acc = 0;
      e.co  = 0;
    end else if (c) begin
      e.co  = (s >= M) ? 1 : 0;
      m_acc = s % M;
    end else begin
      e.co  = 0;
    end
    e.acc = m_acc;
    exp_q.push_back(e);
  endtask

  // Waits until just after the edge that consumes the last step's inputs
  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  // Monitor: every cycle is an output cycle for this block
  initial begin : monitor
    exp_t e;
    int   m;
    forever begin
      @(negedge clk);
      #2;
      if (mx_q.size() > 0) begin
        m = mx_q.pop_front();
        chk("Mx", int'(Mx), m);
      end
      @(posedge clk);
      #1;
      if (CO === 1'b1) co_count++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ACC", int'(ACC), e.acc);
        chk("CO", int'(CO), e.co);
      end
    end
  end

  initial begin : driver
    int co_start;
    rst = 1'b1;
    ce  = 1'b0;
    X   = 8'd0;

    // Reset with ce=1, X=3, then first enabled add
    step(1, 1, 3);
    step(1, 1, 3);
    after_edge();
    chk("reset_acc", int'(ACC), 0);
    chk("reset_co", int'(CO), 0);
    chk("reset_mx", int'(Mx), 0);
    step(0, 1, 3);
    after_edge();
    chk("first_add", int'(ACC), 3);

    // Steady count X=3
    step(1, 0, 3);
    for (int i = 0; i < 666; i++) step(0, 1, 3);
    after_edge();
    chk("steady_1998", int'(ACC), 1998);
    chk("steady_mx", int'(Mx), 1);
    step(0, 1, 3);
    after_edge();
    chk("wrap667_acc", int'(ACC), 1);
    chk("wrap667_co", int'(CO), 1);
    step(0, 1, 3);
    after_edge();
    chk("add668_acc", int'(ACC), 4);
    chk("add668_co", int'(CO), 0);

    // Enable gating
    for (int i = 0; i < 40; i++) step(0, (i % 2) == 0, 3);

    // Exact-boundary wrap
    step(1, 0, 5);
    for (int i = 0; i < 349; i++) step(0, 1, 5);
    step(0, 0, 255);
    after_edge();
    chk("boundary_pre_acc", int'(ACC), 1745);
    chk("boundary_pre_mx", int'(Mx), 1);
    step(0, 1, 255);
    after_edge();
    chk("boundary_acc", int'(ACC), 0);
    chk("boundary_co", int'(CO), 1);

    // Max-input stress
    step(1, 0, 255);
    after_edge();
    co_start = co_count;
    for (int i = 0; i < 2000; i++) step(0, 1, 255);
    after_edge();
    chk("stress_co_pulses", co_count - co_start, 255);
    chk("stress_acc", int'(ACC), 0);

    // Mid-operation reset just before a wrap
    step(1, 0, 3);
    for (int i = 0; i < 666; i++) step(0, 1, 3);
    step(1, 1, 3);
    after_edge();
    chk("midrst_acc", int'(ACC), 0);
    chk("midrst_co", int'(CO), 0);
    chk("midrst_mx", int'(Mx), 0);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(200, 255))
                                       : int'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    #5;
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_mx", mx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
